// File: rtl/fp32_to_int32.sv
// FP32 to INT32 converter: three-stage pipeline with round-toward-zero
// truncation, saturation on overflow and Inf/NaN, and a saturating counter
// of flagged results.
//
// Handshake: in_valid qualifies in_data at every rising edge where stall is
// low, and that edge accepts the operand. out_valid qualifies out_data,
// out_ovf and out_inv. A result is consumed at the first rising edge where
// it is presented with stall low. While stall is high, every stage holds
// its value and the inputs are ignored.
module fp32_to_int32 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             stall,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_ovf,
  output logic             out_inv,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1 registers
  logic        s1_valid;
  logic [31:0] s1_data;

  // Stage 1 field views
  logic [7:0]  s1_exp;
  logic [23:0] s1_man;
  assign s1_exp = s1_data[30:23];
  assign s1_man = {1'b1, s1_data[22:0]};

  // Stage 2 next-state values (unpack and shift)
  logic [31:0] u_mag;
  logic        u_sat;
  logic        u_ovf;
  logic        u_inv;

  // Stage 2 registers
  logic        s2_valid;
  logic        s2_sign;
  logic        s2_sat;
  logic        s2_ovf;
  logic        s2_inv;
  logic [31:0] s2_mag;

  // Stage 3 next-state value (sign and saturation)
  logic [31:0] s3_data;

  // Stage 1: capture the raw operand and its valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
    end
  end

  // Classify the exponent and build the truncated unsigned magnitude.
  // Biased exponent 150 means e = 23: M is already an integer there.
  // Biased exponent 158 means e = 31: only -2^31 itself fits.
  always_comb begin
    u_mag = '0;
    u_sat = 1'b0;
    u_ovf = 1'b0;
    u_inv = 1'b0;
    if (s1_exp == 8'd255) begin
      u_sat = 1'b1;
      u_inv = 1'b1;
    end else if (s1_exp >= 8'd158) begin
      u_sat = 1'b1;
      u_ovf = !(s1_data[31] && (s1_exp == 8'd158) && (s1_data[22:0] == 23'd0));
    end else if (s1_exp >= 8'd150) begin
      u_mag = {8'd0, s1_man} << (s1_exp - 8'd150);
    end else if (s1_exp >= 8'd127) begin
      u_mag = {8'd0, s1_man} >> (8'd150 - s1_exp);
    end
  end

  // Stage 2: register the magnitude and classification
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_sat   <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_inv   <= 1'b0;
      s2_mag   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_data[31];
      s2_sat   <= u_sat;
      s2_ovf   <= u_ovf;
      s2_inv   <= u_inv;
      s2_mag   <= u_mag;
    end
  end

  // Apply saturation or two's-complement negation; -0 negates to 0
  always_comb begin
    s3_data = s2_sign ? (32'd0 - s2_mag) : s2_mag;
    if (s2_sat) begin
      s3_data = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  // Stage 3: registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_inv   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      out_data  <= s3_data;
      out_ovf   <= s2_ovf;
      out_inv   <= s2_inv;
    end
  end

  // Count flagged results as they are consumed; clear has priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (cnt_clr) begin
      ovf_count <= '0;
    end else if (!stall && out_valid && (out_ovf || out_inv) && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule
